// File: rtl/fp_to_fixed.sv
`timescale 1ns/1ps
// IEEE-style float to signed Q(INT.FRAC) converter, one bit of shift per cycle; specials/out-of-range finish at T+1, else T+|s|+2.
// One operand in flight: in_ready only in IDLE, result held in DONE until out_ready.
module fp_to_fixed #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int INT_WIDTH      = 16,
  parameter int FRAC_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          sign,
  input  logic [EXPONENT_WIDTH-1:0]     exponent,
  input  logic [MANTISSA_WIDTH-1:0]     mantissa,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] fixed_out,
  output logic                          overflow,
  output logic                          busy
);

  localparam int OUT_W = INT_WIDTH + FRAC_WIDTH;
  localparam int SIG_W = MANTISSA_WIDTH + 1;
  localparam int MAG_W = (OUT_W > SIG_W) ? OUT_W : SIG_W;
  localparam int BIAS  = (1 << (EXPONENT_WIDTH - 1)) - 1;
  localparam int CNT_W = $clog2(MAG_W + 1) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [MAG_W-1:0]   mag;
  logic [CNT_W-1:0]   count;
  logic               sign_q;
  logic               left_q;
  logic [OUT_W-1:0]   fixed_q;
  logic               ovf_q;

  int                 e_val;
  int                 s_val;
  int                 abs_s;
  logic               special;
  logic               spec_ovf;
  logic [OUT_W-1:0]   spec_val;
  logic [OUT_W-1:0]   sat_val;

  // Classify the incoming operand; everything resolvable without shifting is decided here.
  always_comb begin
    e_val    = int'(exponent) - BIAS;
    s_val    = e_val - MANTISSA_WIDTH + FRAC_WIDTH;
    abs_s    = (s_val < 0) ? -s_val : s_val;
    sat_val  = sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    special  = 1'b1;
    spec_ovf = 1'b0;
    spec_val = '0;
    if (exponent == '0) begin
      spec_val = '0;
    end else if (&exponent) begin
      spec_ovf = 1'b1;
      if (mantissa == '0) spec_val = sat_val;
    end else if (e_val >= INT_WIDTH - 1) begin
      spec_ovf = 1'b1;
      spec_val = sat_val;
    end else if (s_val < -(MANTISSA_WIDTH + 1)) begin
      spec_val = '0;
    end else begin
      special = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : SHIFT;
      SHIFT:   if (count == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag     <= '0;
      count   <= '0;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      fixed_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign;
            if (special) begin
              fixed_q <= spec_val;
              ovf_q   <= spec_ovf;
            end else begin
              mag    <= MAG_W'({1'b1, mantissa});
              count  <= CNT_W'(abs_s);
              left_q <= (s_val > 0);
              ovf_q  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (count != '0) begin
            mag   <= left_q ? (mag << 1) : (mag >> 1);
            count <= count - 1'b1;
          end else begin
            // Range check at acceptance guarantees the magnitude fits below the sign bit.
            fixed_q <= sign_q ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fixed_out = fixed_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/fp_to_fixed.md
FP_TO_FIXED -- requirements
Module: fp_to_fixed

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored mantissa width (hidden bit excluded).
REQ-003 SHALL have parameter INT_WIDTH, default 16, signed integer bits of the output, sign bit included.
REQ-004 SHALL have parameter FRAC_WIDTH, default 16, fractional bits of the output.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have in_valid input 1, input fields valid.
REQ-007 SHALL have in_ready output 1, block can accept an operand.
REQ-008 SHALL have sign input 1, operand sign.
REQ-009 SHALL have exponent input EXPONENT_WIDTH, biased exponent.
REQ-010 SHALL have mantissa input MANTISSA_WIDTH, stored mantissa.
REQ-011 SHALL have out_valid output 1, result valid.
REQ-012 SHALL have out_ready input 1, consumer accepts the result.
REQ-013 SHALL have fixed_out output INT_WIDTH+FRAC_WIDTH, two's-complement fixed-point result.
REQ-014 SHALL have overflow output 1, result saturated or NaN; valid with out_valid.
REQ-015 SHALL have busy output 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE, SHIFT, DONE. in_ready = (state==IDLE).
REQ-017 SHALL accept an operand in cycle T when in_valid && in_ready, latching sign, exponent and mantissa. Fields are ignored outside acceptance.
REQ-018 SHALL compute bias = 2^(EXPONENT_WIDTH-1)-1, e = exponent-bias, and shift s = e - MANTISSA_WIDTH + FRAC_WIDTH. Defaults: s = exponent-134.
REQ-019 SHALL form the significand as {1,mantissa} in a magnitude register at least INT_WIDTH+FRAC_WIDTH bits wide.
REQ-020 Special cases SHALL be resolved at acceptance. FSM goes IDLE->DONE, out_valid at T+1, no shifting:
- exponent==0 (zero/denormal): result 0, overflow=0.
- exponent all-ones, mantissa==0 (infinity): saturate per sign, overflow=1.
- exponent all-ones, mantissa!=0 (NaN): result 0, overflow=1.
- e >= INT_WIDTH-1: saturate per sign, overflow=1.
- s < -(MANTISSA_WIDTH+1): result 0, overflow=0.
REQ-021 Saturation values SHALL be: positive 0x7FFFFFFF, negative 0x80000000 (defaults).
REQ-022 Otherwise the FSM SHALL go IDLE->SHIFT with count=|s|. Each SHIFT cycle with count!=0: shift magnitude one bit (left if s>0, right if s<0, logical, truncating), then count--.
REQ-023 In SHIFT with count==0, SHALL two's-complement negate the magnitude if sign=1, load fixed_out, go to DONE. out_valid rises at T+|s|+2.
REQ-024 Rounding SHALL be truncation toward zero on magnitude. Negative inputs that truncate to 0 SHALL yield 0.
REQ-025 In DONE, out_valid=1 and fixed_out/overflow SHALL be held stable until out_ready=1. The FSM then returns to IDLE the next cycle; the earliest next acceptance is one cycle after the handshake.
REQ-026 out_ready SHALL be ignored outside DONE. No new operand SHALL be accepted in SHIFT or DONE.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, out_valid=0, overflow=0, fixed_out=0, busy=0, count=0. rst overrides in_valid.
REQ-028 rst asserted in SHIFT or DONE SHALL abort the conversion. No out_valid SHALL appear for the aborted operand; in_ready=1 in the cycle after rst deasserts.

Verification
REQ-029 sign=0, exponent=0x81, mantissa=0x740000 (7.625), out_ready=1 -> out_valid at T+7, fixed_out=0x0007A000, overflow=0.
REQ-030 sign=1, exponent=0x82, mantissa=0x200000 (-10.0) -> fixed_out=0xFFF60000, overflow=0. Also 256.0 (exponent=0x87, mantissa=0) -> fixed_out=0x01000000 at T+3.
REQ-031 65536.0 (exponent=0x8F, mantissa=0) -> out_valid at T+1, fixed_out=0x7FFFFFFF, overflow=1. -inf -> 0x80000000, overflow=1. NaN -> 0, overflow=1.
REQ-032 2^-16 (exponent=0x6F, mantissa=0) -> fixed_out=0x00000001. 2^-20 (exponent=0x6B) -> fixed_out=0, out_valid at T+1. exponent=0 -> 0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored. After the out_ready=1 handshake -> in_ready=1 next cycle.
REQ-034 Assert rst for one cycle mid-SHIFT on the 7.625 case -> out_valid never rises for it. A following 13.0 (exponent=0x82, mantissa=0x500000) -> fixed_out=0x000D0000.
